// File: rtl/y86_alu_core_if.sv
// Request/result bundle for the Y86-64 ALU.
// ALU_STATUS_FLAGS_EN adds the zf/sf status outputs.
interface y86_alu_core_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [1:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             flag;
  logic             out_valid;
`ifdef ALU_STATUS_FLAGS_EN
  logic             zf;
  logic             sf;

  modport master (
    output in_valid, operation, a, b,
    input  out, flag, out_valid, zf, sf
  );
  modport slave (
    input  in_valid, operation, a, b,
    output out, flag, out_valid, zf, sf
  );
`else
  modport master (
    output in_valid, operation, a, b,
    input  out, flag, out_valid
  );
  modport slave (
    input  in_valid, operation, a, b,
    output out, flag, out_valid
  );
`endif
endinterface

// File: rtl/y86_alu_core.sv
// Registered 64-bit Y86-64 ALU: add/sub/and/xor plus signed overflow.
// ALU_STATUS_FLAGS_EN adds registered zero/sign status flags.
module y86_alu_core #(
  parameter int WIDTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  y86_alu_core_if.slave   bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             sa;
  logic             sb;
  logic             sr;

  logic [WIDTH-1:0] out_d, out_q;
  logic             flag_d, flag_q;
  logic             valid_d, valid_q;

  assign sa = bus.a[WIDTH-1];
  assign sb = bus.b[WIDTH-1];
  assign sr = res[WIDTH-1];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (bus.operation)
      OP_ADD: begin
        res = bus.a + bus.b;
        ovf = (sa == sb) && (sr != sa);
      end
      OP_SUB: begin
        res = bus.a - bus.b;
        ovf = (sa != sb) && (sr != sa);
      end
      OP_AND: res = bus.a & bus.b;
      OP_XOR: res = bus.a ^ bus.b;
      default: res = '0;
    endcase
  end

  // Result holds while idle; only out_valid tracks the request stream.
  always_comb begin
    out_d   = out_q;
    flag_d  = flag_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      out_d  = res;
      flag_d = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.flag      = flag_q;
  assign bus.out_valid = valid_q;

`ifdef ALU_STATUS_FLAGS_EN
  logic zf_d, zf_q;
  logic sf_d, sf_q;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    if (bus.in_valid) begin
      zf_d = (res == '0);
      sf_d = sr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
    end
  end

  assign bus.zf = zf_q;
  assign bus.sf = sf_q;
`endif

endmodule

// File: tb/tb_y86_alu_core.sv
// Directed plus random checks of y86_alu_core against an arithmetic model.
module tb_y86_alu_core;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MAXN = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] m_out;
  logic        m_flag;
  logic        m_valid;
  logic        m_zf;
  logic        m_sf;

  y86_alu_core_if #(.WIDTH(64)) bus ();

  y86_alu_core #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Overflow from exact integer arithmetic: result does not fit in 64 bits.
  task automatic model(input logic [1:0] op, input logic [63:0] x,
                       input logic [63:0] y, output logic [63:0] r,
                       output logic f);
    logic signed [65:0] exact;
    exact = '0;
    f = 1'b0;
    case (op)
      2'd0: exact = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
      2'd1: exact = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
      2'd2: exact = {2'b00, x & y};
      default: exact = {2'b00, x ^ y};
    endcase
    r = exact[63:0];
    if (op < 2'd2)
      f = (exact > 66'sh0_7FFF_FFFF_FFFF_FFFF) ||
          (exact < -66'sh0_8000_0000_0000_0000);
  endtask

  task automatic step(input logic rn, input logic v, input logic [1:0] op,
                      input logic [63:0] x, input logic [63:0] y,
                      input string tag);
    logic [63:0] r;
    logic f;
    rst_n = rn;
    bus.in_valid = v;
    bus.operation = op;
    bus.a = x;
    bus.b = y;
    model(op, x, y, r, f);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_out = '0; m_flag = 0; m_valid = 0; m_zf = 0; m_sf = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_out = r; m_flag = f; m_zf = (r == 0); m_sf = r[63];
      end
    end
    check({tag, ".out"}, bus.out, m_out);
    check({tag, ".flag"}, {63'd0, bus.flag}, {63'd0, m_flag});
    check({tag, ".valid"}, {63'd0, bus.out_valid}, {63'd0, m_valid});
`ifdef ALU_STATUS_FLAGS_EN
    check({tag, ".zf"}, {63'd0, bus.zf}, {63'd0, m_zf});
    check({tag, ".sf"}, {63'd0, bus.sf}, {63'd0, m_sf});
`endif
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return MAXP;
      1: return MAXN;
      2: return 64'd0;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] x;
    logic [63:0] y;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.operation = 2'd0;
    bus.a = '0;
    bus.b = '0;
    m_out = '0; m_flag = 0; m_valid = 0; m_zf = 0; m_sf = 0;

    step(0, 1, 2'd0, 64'd5, 64'd3, "rst0");
    step(0, 1, 2'd0, 64'd5, 64'd3, "rst1");
    step(1, 1, 2'd0, 64'd5, 64'd3, "first");
    step(1, 1, 2'd0, MAXP, 64'd1, "add_ovf");
    step(1, 1, 2'd0, 64'd10, -64'sd3, "add_neg");
    step(1, 1, 2'd1, 64'h100, 64'd8, "push");
    step(1, 1, 2'd1, MAXN, 64'd1, "sub_ovf");
    step(1, 1, 2'd1, 64'd42, 64'd42, "sub_eq");
    step(1, 1, 2'd2, 64'hF0F0, 64'hFF00, "and");
    step(1, 1, 2'd3, 64'hF0F0, 64'hFF00, "xor");
    step(1, 1, 2'd3, 64'h1234, 64'h1234, "xor_eq");
    step(1, 1, 2'd0, 64'h200, 64'd8, "b2b_add");
    step(1, 1, 2'd1, 64'h200, 64'd8, "b2b_sub");
    step(1, 1, 2'd2, 64'h0FF0, 64'h00FF, "b2b_and");
    step(1, 1, 2'd3, 64'h0FF0, 64'h00FF, "b2b_xor");
    step(1, 0, 2'd0, 64'd1, 64'd1, "hold0");
    step(1, 0, 2'd1, 64'd7, 64'd9, "hold1");
    step(1, 1, 2'd0, MAXN, MAXN, "add_nn");
    step(0, 1, 2'd0, 64'd9, 64'd9, "mid_rst");
    step(1, 1, 2'd1, 64'd0, 64'd1, "post_rst");

    for (int i = 0; i < 300; i++) begin
      x = rnd_operand();
      y = ($urandom_range(0, 9) == 0) ? x : rnd_operand();
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), x, y, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_alu_core.md
Name: y86_alu_core

Overview:
- 64-bit Y86-64 arithmetic/logic unit used by the execute stage.
- Covers OPq, address arithmetic (irmovq/rmmovq/mrmovq) and stack-pointer adjustment (call/ret/pushq/popq).
- Registered single-stage datapath: operands and operation are sampled on a clock edge; result and overflow flag appear one cycle later.

Parameters:
- WIDTH, 64, operand/result width in bits (two's complement).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/operation valid this cycle
- operation  input  2  00 add, 01 sub, 10 and, 11 xor
- a  input  WIDTH  signed operand A (first operand; minuend for sub)
- b  input  WIDTH  signed operand B (second operand; subtrahend for sub)
- out  output  WIDTH  registered signed result
- flag  output  1  registered signed-overflow flag
- out_valid  output  1  out/flag hold a result computed from an accepted input

Behaviour:
- Reset: all of the following happen when rst_n=0 at a rising clk edge.
  - out=0, flag=0, out_valid=0.
  - zf=0 and sf=0 if the feature is enabled.
  - Reset has priority over in_valid.
- Latency is 1 cycle. When in_valid=1 at edge N, out/flag/out_valid reflect that request after edge N.
- If in_valid=0 at an edge:
  - out and flag hold their previous values.
  - out_valid drops to 0.
- Back-to-back: one new request is accepted every cycle. There is no stall or backpressure.
- Arithmetic is modulo 2^WIDTH; carry-out is discarded.
  - add: out = a + b.
  - sub: out = a - b.
  - and: out = a & b.
  - xor: out = a ^ b.
- Overflow (flag):
  - add: flag=1 iff sign(a)==sign(b) and sign(out)!=sign(a).
  - sub: flag=1 iff sign(a)!=sign(b) and sign(out)!=sign(a).
  - and/xor: flag=0.
- Boundary cases:
  - sub of the most-negative value minus 1 wraps to the most-positive value with flag=1.
  - add of the most-positive value plus 1 wraps to the most-negative value with flag=1.
  - a=b under sub gives out=0, flag=0.
- Reset asserted mid-stream discards the in-flight result. The first post-reset request appears normally one cycle after it is accepted.
- Usage (informative):
  - execute stage computes valE = valB - valA with a=valB, b=valA.
  - pushq/call: a=valB, b=8, sub.
  - popq/ret: a=valB, b=8, add.
  - irmovq: a=valC, b=0, add.

Optional Feature:
- Macro: ALU_STATUS_FLAGS_EN.
- Defined: two extra outputs, zf (1 bit) and sf (1 bit).
  - Both are registered alongside out and updated only when in_valid=1.
  - zf=1 iff the next out==0.
  - sf = MSB of the next out.
  - Both reset to 0 and hold when in_valid=0.
- Undefined: neither port exists. The execute stage derives the condition codes itself from out and flag.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, a=5, b=3 -> out=0, flag=0, out_valid=0 throughout; release -> first result one cycle after acceptance.
- Add: op=00, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> next cycle out=0x8000_0000_0000_0000, flag=1 (sf=1, zf=0 if enabled); then a=10, b=-3 -> out=7, flag=0.
- Sub/stack: op=01, a=0x100, b=8 -> out=0xF8, flag=0; a=0x8000_0000_0000_0000, b=1 -> out=0x7FFF_FFFF_FFFF_FFFF, flag=1; a=b=42 -> out=0 (zf=1).
- Logic: op=10, a=0xF0F0, b=0xFF00 -> out=0xF000, flag=0; op=11, same operands -> out=0x0FF0, flag=0; op=11, a=b -> out=0.
- Hold and throughput:
  - Four back-to-back in_valid=1 requests (add, sub, and, xor) -> four consecutive results each one cycle later, out_valid=1 for four cycles.
  - Then in_valid=0 -> out holds the last xor result, out_valid=0.
